// File: rtl/layer_loader.sv
// layer_loader
// Sequences the weight/activation write port of a convolution input layer from
// one valid/ready stream. After start it accepts every kernel weight, then every
// input activation, emitting one registered write strobe per accepted beat with
// the matching 4-D index, then pulses compute and done.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     begin a load (sampled in IDLE only)
//   in_data/in_valid/in_ready stream input
//   write_data                registered data for the layer write
//   want_write_weights/_act   one-cycle write strobes
//   in_index3..in_index0      registered write index
//   compute, done             one-cycle pulses; busy = not IDLE
//
// state   | meaning
// IDLE    | waiting for start
// LOAD_W  | accepting weights (kx, ky, out-ch, in-ch)
// LOAD_A  | accepting activations (x, y, entry)
// FLUSH   | last activation write visible
// COMPUTE | compute pulse
// DONE    | done pulse
module layer_loader #(
  parameter int NUM_INPUTS  = 1,
  parameter int NUM_OUTPUTS = 1,
  parameter int INPUT_DIM   = 5,
  parameter int KERNEL_DIM  = 3,
  parameter int DATA_SIZE   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATA_SIZE-1:0] write_data,
  output logic                 want_write_weights,
  output logic                 want_write_act,
  output logic [15:0]          in_index3,
  output logic [15:0]          in_index2,
  output logic [15:0]          in_index1,
  output logic [15:0]          in_index0,
  output logic                 compute,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_A, FLUSH, COMPUTE, DONE} state_t;

  localparam logic [15:0] KMAX  = 16'(KERNEL_DIM - 1);
  localparam logic [15:0] IMAX  = 16'(INPUT_DIM - 1);
  localparam logic [15:0] NIMAX = 16'(NUM_INPUTS - 1);
  localparam logic [15:0] NOMAX = 16'(NUM_OUTPUTS - 1);

  state_t state_q, state_d;
  logic [15:0] c0_q, c0_d, c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
  logic [15:0] idx0_q, idx0_d, idx1_q, idx1_d, idx2_q, idx2_d, idx3_q, idx3_d;
  logic [DATA_SIZE-1:0] wdata_q, wdata_d;
  logic ww_q, ww_d, wa_q, wa_d;
  logic [15:0] lim0, lim1, lim2, lim3;
  logic accept, last;

  assign in_ready           = (state_q == LOAD_W) || (state_q == LOAD_A);
  assign busy               = (state_q != IDLE);
  assign compute            = (state_q == COMPUTE);
  assign done               = (state_q == DONE);
  assign write_data         = wdata_q;
  assign want_write_weights = ww_q;
  assign want_write_act     = wa_q;
  assign in_index0          = idx0_q;
  assign in_index1          = idx1_q;
  assign in_index2          = idx2_q;
  assign in_index3          = idx3_q;

  always_comb begin
    state_d = state_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    c3_d    = c3_q;
    idx0_d  = idx0_q;
    idx1_d  = idx1_q;
    idx2_d  = idx2_q;
    idx3_d  = idx3_q;
    wdata_d = wdata_q;
    ww_d    = 1'b0;
    wa_d    = 1'b0;
    accept  = in_valid && in_ready;

    // Counter limits depend on which walk is active; c3 is unused for activations.
    if (state_q == LOAD_W) begin
      lim0 = KMAX;
      lim1 = KMAX;
      lim2 = NOMAX;
      lim3 = NIMAX;
    end else begin
      lim0 = IMAX;
      lim1 = IMAX;
      lim2 = NIMAX;
      lim3 = '0;
    end
    last = (c0_q == lim0) && (c1_q == lim1) && (c2_q == lim2) && (c3_q == lim3);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_W;
          c0_d = '0;
          c1_d = '0;
          c2_d = '0;
          c3_d = '0;
        end
      end
      LOAD_W, LOAD_A: begin
        if (accept) begin
          wdata_d = in_data;
          idx0_d  = c0_q;
          idx1_d  = c1_q;
          idx2_d  = c2_q;
          idx3_d  = (state_q == LOAD_W) ? c3_q : 16'd0;
          ww_d    = (state_q == LOAD_W);
          wa_d    = (state_q == LOAD_A);
          if (last) begin
            state_d = (state_q == LOAD_W) ? LOAD_A : FLUSH;
            c0_d = '0;
            c1_d = '0;
            c2_d = '0;
            c3_d = '0;
          end else if (c0_q != lim0) begin
            c0_d = c0_q + 16'd1;
          end else begin
            c0_d = '0;
            if (c1_q != lim1) begin
              c1_d = c1_q + 16'd1;
            end else begin
              c1_d = '0;
              if (c2_q != lim2) begin
                c2_d = c2_q + 16'd1;
              end else begin
                c2_d = '0;
                c3_d = c3_q + 16'd1;
              end
            end
          end
        end
      end
      FLUSH:   state_d = COMPUTE;
      COMPUTE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c0_q    <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      c3_q    <= '0;
      idx0_q  <= '0;
      idx1_q  <= '0;
      idx2_q  <= '0;
      idx3_q  <= '0;
      wdata_q <= '0;
      ww_q    <= 1'b0;
      wa_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      c3_q    <= c3_d;
      idx0_q  <= idx0_d;
      idx1_q  <= idx1_d;
      idx2_q  <= idx2_d;
      idx3_q  <= idx3_d;
      wdata_q <= wdata_d;
      ww_q    <= ww_d;
      wa_q    <= wa_d;
    end
  end

endmodule

// File: tb/tb_layer_loader.sv
`timescale 1ns/1ps
// Two loaders: u0 with default parameters, u1 multichannel (2,2,in 3,k 2).
module tb_layer_loader;

  typedef struct packed {
    logic        act;
    logic [63:0] data;
    logic [15:0] i3, i2, i1, i0;
  } rec_t;

  localparam int NI[2] = '{1, 2};
  localparam int NO[2] = '{1, 2};
  localparam int ID[2] = '{5, 3};
  localparam int KD[2] = '{3, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2], start[2], in_valid[2], in_ready[2];
  logic        ww[2], wa[2], compute[2], busy[2], done[2];
  logic [63:0] in_data[2], wdata[2];
  logic [15:0] ix3[2], ix2[2], ix1[2], ix0[2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  rec_t q0[$];
  rec_t q1[$];
  int nw[2], na[2], ncomp[2], ndone[2], last_acc[2];
  int first_w[2], last_w[2], first_a[2], last_a[2], comp_cyc[2], done_cyc[2];

  layer_loader u0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .in_data(in_data[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .write_data(wdata[0]),
    .want_write_weights(ww[0]), .want_write_act(wa[0]),
    .in_index3(ix3[0]), .in_index2(ix2[0]), .in_index1(ix1[0]), .in_index0(ix0[0]),
    .compute(compute[0]), .busy(busy[0]), .done(done[0])
  );

  layer_loader #(.NUM_INPUTS(2), .NUM_OUTPUTS(2), .INPUT_DIM(3), .KERNEL_DIM(2),
                 .DATA_SIZE(64)) u1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .in_data(in_data[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .write_data(wdata[1]),
    .want_write_weights(ww[1]), .want_write_act(wa[1]),
    .in_index3(ix3[1]), .in_index2(ix2[1]), .in_index1(ix1[1]), .in_index0(ix0[1]),
    .compute(compute[1]), .busy(busy[1]), .done(done[1])
  );

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h required %0h", name, cyc, got, exp);
    end
  endtask

  // Expected write for beat k, derived by division rather than counting.
  function automatic rec_t model(input int d, input int k);
    rec_t r;
    int kd, id, no, w, a;
    kd = KD[d]; id = ID[d]; no = NO[d];
    w  = NI[d] * no * kd * kd;
    r.data = $realtobits(real'(k));
    if (k < w) begin
      r.act = 1'b0;
      r.i0  = 16'(k % kd);
      r.i1  = 16'((k / kd) % kd);
      r.i2  = 16'((k / (kd * kd)) % no);
      r.i3  = 16'(k / (kd * kd * no));
    end else begin
      a     = k - w;
      r.act = 1'b1;
      r.i0  = 16'(a % id);
      r.i1  = 16'((a / id) % id);
      r.i2  = 16'(a / (id * id));
      r.i3  = 16'd0;
    end
    return r;
  endfunction

  task automatic mon(input int d);
    rec_t r;
    bit empty;
    if (ww[d] === 1'b1 || wa[d] === 1'b1) begin
      chk("strobe_exclusive", 64'(ww[d] & wa[d]), 64'd0);
      empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe dut%0d @cyc %0d: got w=%0b a=%0b required none", d, cyc, ww[d], wa[d]);
      end else begin
        if (d == 0) r = q0.pop_front();
        else        r = q1.pop_front();
        chk("strobe_kind", 64'(wa[d]), 64'(r.act));
        chk("write_data", wdata[d], r.data);
        chk("write_index", {ix3[d], ix2[d], ix1[d], ix0[d]}, {r.i3, r.i2, r.i1, r.i0});
      end
      if (wa[d] === 1'b1) begin
        na[d]++;
        if (first_a[d] < 0) first_a[d] = cyc;
        last_a[d] = cyc;
      end else begin
        nw[d]++;
        if (first_w[d] < 0) first_w[d] = cyc;
        last_w[d] = cyc;
      end
    end
    if (compute[d] === 1'b1) begin
      ncomp[d]++;
      comp_cyc[d] = cyc;
      chk("compute_latency", 64'(cyc), 64'(last_acc[d] + 2));
    end
    if (done[d] === 1'b1) begin
      ndone[d]++;
      done_cyc[d] = cyc;
      chk("done_after_compute", 64'(cyc), 64'(comp_cyc[d] + 1));
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon(d);
  end

  // Drives one load on DUT d. stall toggles in_valid; abort_k asserts rst when
  // beat abort_k would be presented; extra_start pulses start in LOAD_A and DONE.
  task automatic run_load(input int d, input bit stall, input int abort_k,
                          input bit extra_start, output int t0);
    int k, total, w, budget, c0, d0, lq;
    bit v;
    k = 0; budget = 0;
    w = NI[d] * NO[d] * KD[d] * KD[d];
    total = w + NI[d] * ID[d] * ID[d];
    nw[d] = 0; na[d] = 0;
    first_w[d] = -1; first_a[d] = -1; last_w[d] = -1; last_a[d] = -1;
    c0 = ncomp[d]; d0 = ndone[d];
    @(negedge clk);
    start[d] = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start[d] = 1'b0;
    while (k < total && budget < 1000) begin
      if (k == abort_k) begin
        rst[d] = 1'b1;
        in_valid[d] = 1'b1;
        in_data[d] = $realtobits(real'(k));
        @(negedge clk);
        rst[d] = 1'b0;
        in_valid[d] = 1'b0;
        return;
      end
      v = !stall || (budget % 2 == 0);
      in_valid[d] = v;
      in_data[d]  = $realtobits(real'(k));
      start[d]    = extra_start && (k == w + 3);
      if (v && in_ready[d] === 1'b1) begin
        if (d == 0) q0.push_back(model(d, k));
        else        q1.push_back(model(d, k));
        last_acc[d] = cyc;
        k++;
      end
      budget++;
      @(negedge clk);
    end
    in_valid[d] = 1'b0;
    start[d] = 1'b0;
    if (k < total) begin
      n_checks++;
      n_fail++;
      $display("FAIL load_timeout dut%0d: got %0d beats required %0d", d, k, total);
    end
    for (int i = 0; i < 6; i++) begin
      if (cyc == last_acc[d] + 1) begin
        chk("ready_low_flush", 64'(in_ready[d]), 64'd0);
        chk("busy_flush", 64'(busy[d]), 64'd1);
      end
      start[d] = extra_start && (cyc == last_acc[d] + 3);
      if (cyc == last_acc[d] + 4 || cyc == last_acc[d] + 6)
        chk("busy_low_after_done", 64'(busy[d]), 64'd0);
      @(negedge clk);
    end
    start[d] = 1'b0;
    chk("compute_count", 64'(ncomp[d] - c0), 64'd1);
    chk("done_count", 64'(ndone[d] - d0), 64'd1);
    lq = (d == 0) ? q0.size() : q1.size();
    chk("queue_drained", 64'(lq), 64'd0);
    chk("weight_writes", 64'(nw[d]), 64'(w));
    chk("act_writes", 64'(na[d]), 64'(total - w));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, cb;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b1; in_valid[d] = 1'b1; in_data[d] = 64'hFFFF;
      ncomp[d] = 0; ndone[d] = 0; last_acc[d] = 0; comp_cyc[d] = 0;
    end
    // Reset with start and valid held high
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("rst_ready", 64'(in_ready[d]), 64'd0);
        chk("rst_strobes", 64'({ww[d], wa[d]}), 64'd0);
        chk("rst_data", wdata[d], 64'd0);
        chk("rst_index", {ix3[d], ix2[d], ix1[d], ix0[d]}, 64'd0);
        chk("rst_ctl", 64'({compute[d], busy[d], done[d]}), 64'd0);
      end
    end
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; start[d] = 1'b0; in_valid[d] = 1'b0;
    end
    @(negedge clk);
    chk("idle_busy", 64'(busy[0]), 64'd0);

    // Full load, default parameters, absolute timing
    run_load(0, 1'b0, -1, 1'b0, t0);
    chk("first_w", 64'(first_w[0]), 64'(t0 + 2));
    chk("last_w", 64'(last_w[0]), 64'(t0 + 10));
    chk("first_a", 64'(first_a[0]), 64'(t0 + 11));
    chk("last_a", 64'(last_a[0]), 64'(t0 + 35));
    chk("compute_cyc", 64'(comp_cyc[0]), 64'(t0 + 36));
    chk("done_cyc", 64'(done_cyc[0]), 64'(t0 + 37));

    // Stalled stream
    run_load(0, 1'b1, -1, 1'b0, t0);

    // Multichannel instance
    run_load(1, 1'b0, -1, 1'b0, t0);
    chk("mc_last_w_idx", 64'(last_w[1] >= 0), 64'd1);

    // Abort during activation beat 10, then a clean reload
    cb = ncomp[0];
    run_load(0, 1'b0, 9 + 10, 1'b0, t0);
    chk("abort_busy", 64'(busy[0]), 64'd0);
    chk("abort_ready", 64'(in_ready[0]), 64'd0);
    chk("abort_queue", 64'(q0.size()), 64'd0);
    in_valid[0] = 1'b1;
    repeat (6) @(negedge clk);
    in_valid[0] = 1'b0;
    chk("abort_no_compute", 64'(ncomp[0] - cb), 64'd0);
    chk("abort_weights_seen", 64'(nw[0]), 64'd9);
    chk("abort_acts_seen", 64'(na[0]), 64'd10);
    run_load(0, 1'b0, -1, 1'b0, t0);

    // start pulses in LOAD_A and DONE are ignored
    run_load(0, 1'b1, -1, 1'b1, t0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_loader.md
# layer_loader

Sequencer that drives the parameter/activation write port of a convolution input layer from a single valid/ready data stream. After `start`, it accepts every kernel weight and then every input activation in a fixed index order. It emits one registered write strobe per accepted beat, with the matching 4-D index. When the last write has landed, it pulses `compute` and then `done`. It sits between the host/testbench data source and the layer.

## Interface

Parameters:
- `NUM_INPUTS`, 1: input channels.
- `NUM_OUTPUTS`, 1: output channels.
- `INPUT_DIM`, 5: activation plane is INPUT_DIM x INPUT_DIM.
- `KERNEL_DIM`, 3: kernel is KERNEL_DIM x KERNEL_DIM.
- `DATA_SIZE`, 64: data word width (IEEE double bit pattern, passed through untouched).

All parameters are at least 1. Every index value fits in 16 bits.

Ports:
- `clk` in 1: clock. One clock domain; everything updates on the posedge.
- `rst` in 1: reset. Synchronous, active-high.
- `start` in 1: begin a load sequence. Sampled only in IDLE.
- `in_data` in DATA_SIZE: stream payload.
- `in_valid` in 1: payload valid.
- `in_ready` out 1: loader can accept a beat.
- `write_data` out DATA_SIZE: data for the layer write.
- `want_write_weights` out 1: weight write strobe.
- `want_write_act` out 1: activation write strobe.
- `in_index3`, `in_index2`, `in_index1`, `in_index0` out 16 each: write index.
- `compute` out 1: one-cycle pulse telling the layer to compute.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation

- States: IDLE, LOAD_W, LOAD_A, FLUSH, COMPUTE, DONE.
- IDLE:
  - `start`=1 moves to LOAD_W next cycle and clears all counters.
  - `start` outside IDLE is ignored.
- A beat is accepted when `in_valid && in_ready`. `in_ready` = (state==LOAD_W || state==LOAD_A), decoded from the state register only and never from `in_valid`.
- LOAD_W accepts W = NUM_INPUTS*NUM_OUTPUTS*KERNEL_DIM^2 beats. The index walk is kx fastest, then ky, then out-channel, then in-channel.
  - `in_index3` = input channel, `in_index2` = output channel, `in_index1` = ky, `in_index0` = kx.
  - Acceptance of beat W-1 moves to LOAD_A with counters cleared. No bubble: `in_ready` stays high across the switch.
- LOAD_A accepts A = NUM_INPUTS*INPUT_DIM^2 beats. The index walk is x fastest, then y, then entry.
  - `in_index3` = 0, `in_index2` = entry, `in_index1` = y, `in_index0` = x.
  - Acceptance of beat A-1 moves to FLUSH.
- FLUSH lasts one cycle (the last activation write is visible). Then COMPUTE for one cycle (`compute`=1), then DONE for one cycle (`done`=1), then IDLE.
- Counters wrap to 0 at their dimension limit and carry into the next counter. Comparisons use the parameter values minus 1. No arithmetic is applied to the data.
- `in_valid` low during LOAD_W/LOAD_A: the FSM holds, counters hold, and no strobe is emitted.

## Timing

- Write latency is 1 cycle. A beat accepted in cycle n gives, in cycle n+1, the strobe (`want_write_weights` or `want_write_act`), `write_data`=`in_data`(n), and the index of that beat.
- Strobes last exactly one cycle per beat, and the two strobes are never high together.
- Indices and `write_data` hold their last value while the strobes are low.
- `compute` rises exactly 2 cycles after the last activation is accepted, which is 1 cycle after the last write strobe. `done` follows 1 cycle later.
- Reset values (cycle after `rst`=1) are all 0: `in_ready`, both strobes, `write_data`, all indices, `compute`, `busy`, `done`. State is IDLE.
- `rst` mid-sequence aborts immediately: no further strobes, no `compute`, and the partial load is discarded. `rst` has priority over `start` and over beat acceptance.
- `start` held high through DONE does not retrigger until the FSM is back in IDLE. A re-start is possible starting the cycle after DONE.

## Test plan

- **Reset:** assert `rst` for 2 cycles with `in_valid`=1 and `start`=1 -> all outputs 0, `in_ready`=0, no strobe.
- **Full load, defaults:** `start` at cycle 0, then `in_valid`=1 every cycle with data = beat number as a double. Required response:
  - weight strobes in cycles 2..10, with index (0,0,0,0)..(0,0,2,2);
  - act strobes in cycles 11..35, with index (0,0,0,0)..(0,0,4,4);
  - `in_ready` low from cycle 35;
  - `compute` in cycle 36, `done` in cycle 37, `busy` low in cycle 38.
- **Stalls:** `in_valid` toggles 1,0,1,0 -> one strobe per accepted beat only, indices contiguous, 25+9 strobes total, `compute` 2 cycles after the last acceptance.
- **Multichannel:** NUM_INPUTS=2, NUM_OUTPUTS=2, KERNEL_DIM=2, INPUT_DIM=3 -> 16 weight writes ending at index (1,1,1,1), 18 act writes ending at (0,1,2,2), then `compute`.
- **Abort:** `rst` during act beat 10 -> no strobe in the next cycle, `compute` never fires. A new `start` gives a full sequence again from weight index (0,0,0,0).
- **Ignored start:** `start` pulses during LOAD_A and in DONE -> sequence unaffected, exactly one `compute` and one `done`.
